// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting in front of the controller/decoder.
// It holds the program counter and fetches one 32-bit word at a time over a
// req/ack handshake. It presents the instruction and its op field for decode
// until the datapath retires it, then steps to the next PC.
// Optional build macro: FETCH_TIMEOUT_EN adds a bounded wait for imem_ack.
// With the macro defined, an expired wait sets a sticky fetch_err and parks the stage.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          OP_MSB   = 31,
  parameter int          OP_LSB   = 27,
  parameter int          TIMEOUT  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  output logic [31:0]              instr,
  output logic [OP_MSB-OP_LSB:0]   op,
  output logic                     instr_valid,
  input  logic                     instr_done,
  input  logic                     pcsrc,
  input  logic                     jump,
  input  logic [15:0]              branch_imm,
  input  logic [25:0]              jump_target,
  output logic [31:0]              pc,
  output logic [31:0]              pc_plus4,
  output logic                     fetch_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  // Memory always sees the current PC; the op field is a plain slice of the latched word.
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign op        = instr[OP_MSB:OP_LSB];

  // Word offset, sign-extended and scaled to bytes.
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  // Select the successor PC. A jump takes priority over a taken branch.
  always_comb begin
    // NOTE: next_pc gets a value on every path first, so no latch can be inferred.
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jump_target, 2'b00};
    end else if (pcsrc) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // Count FETCH cycles without an ack; the count restarts on every entry to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != FETCH) begin
      wait_cnt <= '0;
    end else if (!imem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  // Fetch sequencer: BOOT -> FETCH (wait for ack) -> HOLD (wait for retire) -> FETCH.
  // All handshake outputs and the PC are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_err   <= 1'b0;
`endif
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register
      // in this block samples the values from before the clock edge.
      case (state)
        BOOT: begin
          imem_req <= 1'b1;
          state    <= FETCH;
        end

        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            fetch_err <= 1'b1;
            imem_req  <= 1'b0;
            state     <= HOLD;
          end
`endif
        end

        HOLD: begin
          // A parked stage (instr_valid low) never leaves HOLD.
          if (instr_done && instr_valid) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end

        default: begin
          state       <= BOOT;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
